// File: rtl/guess_entry_controller.sv
// Guess entry controller: assembles a 4-digit hex guess, offers it to the checker
// over a valid/ack handshake, and tracks attempts and the win/lose outcome.
module guess_entry_controller #(
    parameter int unsigned MAX_ATTEMPTS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_in,
    input  logic        digit_load,
    input  logic        backspace,
    input  logic        submit,
    input  logic        new_game,
    output logic [15:0] guess,
    output logic        guess_valid,
    input  logic        guess_ack,
    input  logic [3:0]  correct_place_count,
    input  logic [3:0]  wrong_place_count,
    output logic [2:0]  entry_count,
    output logic [3:0]  attempts,
    output logic [3:0]  last_correct,
    output logic [3:0]  last_wrong,
    output logic        win,
    output logic        lose,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        ENTRY,
        WAIT_ACK,
        WIN,
        LOSE
    } state_t;

    state_t     state;
    logic [3:0] attempts_next;
    logic [4:0] score_sum;

    always_comb begin
        attempts_next = attempts + 4'd1;
        score_sum     = {1'b0, correct_place_count} + {1'b0, wrong_place_count};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ENTRY;
            guess        <= '0;
            guess_valid  <= 1'b0;
            entry_count  <= '0;
            attempts     <= '0;
            last_correct <= '0;
            last_wrong   <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
            proto_err    <= 1'b0;
        end else if (new_game) begin
            state        <= ENTRY;
            guess        <= '0;
            guess_valid  <= 1'b0;
            entry_count  <= '0;
            attempts     <= '0;
            last_correct <= '0;
            last_wrong   <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    // An ignored backspace/load still consumes the cycle, blocking submit.
                    if (backspace) begin
                        if (entry_count != 3'd0) begin
                            guess       <= {4'h0, guess[15:4]};
                            entry_count <= entry_count - 3'd1;
                        end
                    end else if (digit_load) begin
                        if (entry_count < 3'd4) begin
                            guess       <= {guess[11:0], digit_in};
                            entry_count <= entry_count + 3'd1;
                        end
                    end else if (submit && entry_count == 3'd4) begin
                        state       <= WAIT_ACK;
                        guess_valid <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (guess_ack && guess_valid) begin
                        guess_valid  <= 1'b0;
                        last_correct <= correct_place_count;
                        last_wrong   <= wrong_place_count;
                        attempts     <= attempts_next;
                        if (score_sum > 5'd4) begin
                            proto_err <= 1'b1;
                        end
                        if (correct_place_count == 4'd4) begin
                            state <= WIN;
                            win   <= 1'b1;
                        end else if (attempts_next == 4'(MAX_ATTEMPTS)) begin
                            state <= LOSE;
                            lose  <= 1'b1;
                        end else begin
                            state       <= ENTRY;
                            guess       <= '0;
                            entry_count <= '0;
                        end
                    end
                end
                WIN, LOSE: begin
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry_controller.sv
// Directed self-checking bench for guess_entry_controller (MAX_ATTEMPTS = 2).
module tb_guess_entry_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  digit_in;
    logic        digit_load;
    logic        backspace;
    logic        submit;
    logic        new_game;
    logic [15:0] guess;
    logic        guess_valid;
    logic        guess_ack;
    logic [3:0]  correct_place_count;
    logic [3:0]  wrong_place_count;
    logic [2:0]  entry_count;
    logic [3:0]  attempts;
    logic [3:0]  last_correct;
    logic [3:0]  last_wrong;
    logic        win;
    logic        lose;
    logic        proto_err;

    int unsigned passed = 0;
    int unsigned total  = 0;

    guess_entry_controller #(.MAX_ATTEMPTS(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .digit_in            (digit_in),
        .digit_load          (digit_load),
        .backspace           (backspace),
        .submit              (submit),
        .new_game            (new_game),
        .guess               (guess),
        .guess_valid         (guess_valid),
        .guess_ack           (guess_ack),
        .correct_place_count (correct_place_count),
        .wrong_place_count   (wrong_place_count),
        .entry_count         (entry_count),
        .attempts            (attempts),
        .last_correct        (last_correct),
        .last_wrong          (last_wrong),
        .win                 (win),
        .lose                (lose),
        .proto_err           (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] d);
        digit_in   = d;
        digit_load = 1'b1;
        step();
        digit_load = 1'b0;
    endtask

    task automatic pulse_backspace();
        backspace = 1'b1;
        step();
        backspace = 1'b0;
    endtask

    task automatic pulse_submit();
        submit = 1'b1;
        step();
        submit = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic ack(input logic [3:0] c, input logic [3:0] w);
        correct_place_count = c;
        wrong_place_count   = w;
        guess_ack           = 1'b1;
        step();
        guess_ack           = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_guess"}, guess, 16'h0000);
        chk({tag, "_valid"}, 16'(guess_valid), 16'h0);
        chk({tag, "_entry"}, 16'(entry_count), 16'h0);
        chk({tag, "_attempts"}, 16'(attempts), 16'h0);
        chk({tag, "_lastc"}, 16'(last_correct), 16'h0);
        chk({tag, "_lastw"}, 16'(last_wrong), 16'h0);
        chk({tag, "_winlose"}, 16'({win, lose}), 16'h0);
        chk({tag, "_proto"}, 16'(proto_err), 16'h0);
    endtask

    initial begin
        reset = 1'b0; digit_in = '0; digit_load = 1'b0; backspace = 1'b0;
        submit = 1'b0; new_game = 1'b0; guess_ack = 1'b0;
        correct_place_count = '0; wrong_place_count = '0;
        step(); step();
        chk_cleared("reset");
        reset = 1'b1;
        step();

        // Entry and win with a two-cycle ack delay
        load(4'h1); load(4'h2); load(4'h3); load(4'h4);
        chk("win_guess", guess, 16'h1234);
        chk("win_entry", 16'(entry_count), 16'd4);
        pulse_submit();
        chk("win_valid", 16'(guess_valid), 16'h1);
        step(); step();
        chk("win_hold_valid", 16'(guess_valid), 16'h1);
        chk("win_hold_guess", guess, 16'h1234);
        ack(4'd4, 4'd0);
        chk("win_flag", 16'({win, lose}), 16'b10);
        chk("win_attempts", 16'(attempts), 16'd1);
        chk("win_lastc", 16'(last_correct), 16'd4);
        chk("win_valid_drop", 16'(guess_valid), 16'h0);
        chk("win_guess_held", guess, 16'h1234);
        load(4'h5);
        chk("win_terminal", guess, 16'h1234);
        new_game   = 1'b1;
        digit_in   = 4'h9;
        digit_load = 1'b1;
        step();
        new_game   = 1'b0;
        digit_load = 1'b0;
        chk_cleared("newgame");

        // Edit rules
        pulse_backspace();
        chk("bs_empty", 16'(entry_count), 16'd0);
        load(4'hA); load(4'hB); load(4'hC);
        pulse_submit();
        chk("submit_short", 16'(guess_valid), 16'h0);
        pulse_backspace();
        chk("bs_guess", guess, 16'h00AB);
        load(4'hD);
        backspace  = 1'b1;
        digit_load = 1'b1;
        digit_in   = 4'h7;
        step();
        backspace  = 1'b0;
        digit_load = 1'b0;
        chk("bs_priority", guess, 16'h00AB);
        load(4'hD); load(4'hE);
        chk("edit_guess", guess, 16'hABDE);
        chk("edit_entry", 16'(entry_count), 16'd4);
        load(4'hF);
        chk("load_full", guess, 16'hABDE);
        chk("load_full_entry", 16'(entry_count), 16'd4);

        // Handshake hold under stray inputs, then a non-winning score
        pulse_submit();
        for (int i = 0; i < 5; i++) begin
            digit_in = 4'h3; digit_load = 1'b1; backspace = 1'b1; submit = 1'b1;
            step();
        end
        digit_load = 1'b0; backspace = 1'b0; submit = 1'b0;
        chk("hold_guess", guess, 16'hABDE);
        chk("hold_valid", 16'(guess_valid), 16'h1);
        ack(4'd1, 4'd2);
        chk("miss_guess", guess, 16'h0000);
        chk("miss_entry", 16'(entry_count), 16'd0);
        chk("miss_attempts", 16'(attempts), 16'd1);
        chk("miss_valid", 16'(guess_valid), 16'h0);
        chk("miss_lastw", 16'(last_wrong), 16'd2);
        ack(4'd4, 4'd0);
        chk("stray_ack", 16'(attempts), 16'd1);
        chk("stray_ack_win", 16'(win), 16'h0);

        // Second miss exhausts MAX_ATTEMPTS=2
        load(4'h1); load(4'h2); load(4'h3); load(4'h5);
        pulse_submit();
        ack(4'd1, 4'd2);
        chk("lose_flag", 16'({win, lose}), 16'b01);
        chk("lose_attempts", 16'(attempts), 16'd2);
        chk("lose_lastw", 16'(last_wrong), 16'd2);
        chk("lose_guess", guess, 16'h1235);
        pulse_submit();
        ack(4'd1, 4'd2);
        chk("lose_terminal", 16'(attempts), 16'd2);

        // Protocol error, then abort from WAIT_ACK
        pulse_new_game();
        load(4'h6); load(4'h7); load(4'h8); load(4'h9);
        pulse_submit();
        ack(4'd3, 4'd3);
        chk("proto_set", 16'(proto_err), 16'h1);
        chk("proto_lastc", 16'(last_correct), 16'd3);
        chk("proto_attempts", 16'(attempts), 16'd1);
        load(4'h1); load(4'h1); load(4'h1); load(4'h1);
        chk("proto_sticky", 16'(proto_err), 16'h1);
        pulse_submit();
        chk("abort_pre_valid", 16'(guess_valid), 16'h1);
        pulse_new_game();
        chk_cleared("abort");
        load(4'h2);
        chk("abort_entry_state", 16'(entry_count), 16'd1);

        // Asynchronous reset between clock edges
        load(4'h3); load(4'h4); load(4'h5);
        pulse_submit();
        chk("async_pre_valid", 16'(guess_valid), 16'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_cleared("async");
        step();
        reset = 1'b1;
        step();
        chk_cleared("async_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/guess_entry_controller.md
Name: guess_entry_controller

Overview:
Producer side of the guess interface. It assembles a 4-digit hex guess from player digit entry and presents it to the guess checker over a valid/ack handshake. It captures the returned correct/wrong-place counts, tracks attempts and declares win or lose. It sits between the debounced front-panel inputs and the guess checker, in parallel with the secret-number digit selectors.

Parameters:
MAX_ATTEMPTS, 10, number of scored guesses before lose; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
digit_in  input  4  hex digit from switches, sampled on digit_load
digit_load  input  1  single-cycle pulse: append digit_in to guess
backspace  input  1  single-cycle pulse: remove last entered digit
submit  input  1  single-cycle pulse: offer completed guess to checker
new_game  input  1  single-cycle pulse: restart game from any state
guess  output  16  assembled guess; first entered digit in [15:12]
guess_valid  output  1  guess offered to checker
guess_ack  input  1  checker accepted; counts valid this cycle
correct_place_count  input  4  checker result, sampled on guess_ack
wrong_place_count  input  4  checker result, sampled on guess_ack
entry_count  output  3  digits entered, 0..4
attempts  output  4  scored guesses so far
last_correct  output  4  correct-place count of last scored guess
last_wrong  output  4  wrong-place count of last scored guess
win  output  1  game won, held
lose  output  1  attempts exhausted without win, held
proto_err  output  1  sticky: checker returned correct+wrong > 4

Behaviour:
- Reset (reset=0), asynchronous: state=ENTRY. guess, entry_count, attempts, last_correct, last_wrong, guess_valid, win, lose and proto_err are all 0.
- new_game pulse in any state: next cycle same values as reset. It overrides every other input that cycle. Aborting in WAIT_ACK drops guess_valid with no ack required.
- States: ENTRY, WAIT_ACK, WIN, LOSE. All outputs are registered.
- ENTRY, one action per cycle, priority: backspace > digit_load > submit.
  - backspace with entry_count>0: guess <= {4'h0, guess[15:4]}, entry_count-1. At entry_count 0 it is ignored.
  - digit_load with entry_count<4: guess <= {guess[11:0], digit_in}, entry_count+1. At entry_count 4 it is ignored; guess is unchanged.
  - submit with entry_count==4 and no backspace/digit_load that cycle: go to WAIT_ACK, guess_valid=1 from the next cycle. With entry_count<4 it is ignored.
  - Digit order: after entering A,B,C,D the guess is 16'hABCD.
- WAIT_ACK:
  - guess and guess_valid are held stable until the ack. digit_load, backspace and submit are ignored.
  - guess_ack while guess_valid=1 completes the handshake, one transfer per ack. Next cycle:
    - guess_valid=0.
    - last_correct/last_wrong <= sampled counts.
    - attempts+1.
    - proto_err is set if correct+wrong > 4, using a 5-bit sum.
  - Next state on that ack:
    - correct_place_count==4: WIN. win=1, and guess is held for display.
    - else attempts+1 == MAX_ATTEMPTS: LOSE. lose=1, and guess is held.
    - else: ENTRY, with guess=0 and entry_count=0.
  - guess_ack while guess_valid=0 (any state) is ignored.
- WIN/LOSE: terminal. All inputs except new_game and reset are ignored. attempts never exceeds MAX_ATTEMPTS.
- win and lose are never both 1.
- Ack latency is unbounded: guess_ack may arrive in the first cycle guess_valid is high or any later cycle.

Test Plan:
- Entry + win: reset low then high; load 1,2,3,4; submit; ack 2 cycles later with correct=4, wrong=0 -> guess=16'h1234 held with guess_valid=1 until ack. Next cycle: win=1, attempts=1, last_correct=4, guess_valid=0.
- Edit rules: load A,B,C; backspace; load D,E -> guess=16'hABDE, entry_count=4. A 5th load leaves 16'hABDE. Submit at entry_count=3 (earlier) -> no guess_valid.
- Lose: MAX_ATTEMPTS=2. Two guesses acked with correct=1, wrong=2 -> after 1st ack: ENTRY, guess=0, attempts=1. After 2nd ack: lose=1, win=0, attempts=2, last_wrong=2.
- Handshake hold: in WAIT_ACK pulse digit_load/backspace/submit for 5 cycles with no ack -> guess and guess_valid unchanged. Stray ack in ENTRY -> attempts unchanged.
- Protocol error + abort: ack with correct=3, wrong=3 -> proto_err=1 (sticky). Next guess in WAIT_ACK, pulse new_game -> next cycle guess_valid=0, attempts=0, proto_err=0, state ENTRY.
- Async reset mid-handshake: drive reset=0 between clock edges while guess_valid=1 -> all outputs 0 immediately without a clock edge. They stay 0 after reset releases.
